// File: rtl/conv_layer_seq.sv
// Sequencer for one convolution layer: walks the iterator pixel by pixel, fetching the
// bias per channel, gating the MAC and issuing one output-memory write per pixel.
module conv_layer_seq #(
  parameter int CONV_DIM_OUT = 32,
  parameter int CONV_OUT_CH  = 32,
  parameter int ADDR_W       = 16,
  parameter int BIAS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              it_en_ctrl,
  output logic              it_rst,
  input  logic              it_en_sum,
  input  logic              it_fin,
  input  logic [7:0]        it_i,
  input  logic [7:0]        it_j,
  input  logic [7:0]        it_k,
  output logic              bias_rd,
  output logic [7:0]        bias_addr,
  input  logic              bias_valid,
  output logic              acc_ld,
  output logic              acc_en,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr
);
  localparam int          BT_W   = $clog2(BIAS_TIMEOUT + 1);
  localparam logic [31:0] EXP_WR = 32'(CONV_OUT_CH * CONV_DIM_OUT * CONV_DIM_OUT);

  typedef enum logic [2:0] {IDLE, INIT, BIAS, RUN, SAVE, DRAIN, DONE} state_t;

  state_t          state, state_d;
  logic [7:0]      ci, cj, ck;
  logic [31:0]     wr_cnt;
  logic [BT_W-1:0] bias_cnt;
  logic            drain_cnt;
  logic            err_q;
  logic            lat_zero, lat_new, err_set, err_clr;
  logic            coord_chg;
  logic [31:0]     addr_full;

  assign coord_chg = {it_i, it_j, it_k} != {ci, cj, ck};
  assign addr_full = 32'(ci) * 32'(CONV_DIM_OUT * CONV_DIM_OUT)
                   + 32'(cj) * 32'(CONV_DIM_OUT) + 32'(ck);
  assign err       = err_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    lat_zero   = 1'b0;
    lat_new    = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    it_en_ctrl = 1'b0;
    it_rst     = 1'b0;
    bias_rd    = 1'b0;
    bias_addr  = 8'd0;
    acc_ld     = 1'b0;
    acc_en     = 1'b0;
    out_wr     = 1'b0;
    out_addr   = '0;
    unique case (state)
      IDLE: if (start) begin
        state_d  = INIT;
        lat_zero = 1'b1;
        err_clr  = 1'b1;
      end
      INIT: begin
        it_rst  = 1'b1;
        state_d = BIAS;
      end
      BIAS: begin
        bias_rd   = 1'b1;
        bias_addr = ci;
        if (bias_valid) begin
          acc_ld  = 1'b1;
          state_d = RUN;
        end else if (bias_cnt == BT_W'(BIAS_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        it_en_ctrl = 1'b1;
        acc_en     = it_en_sum;
        if (coord_chg || it_fin) state_d = SAVE;
      end
      SAVE: begin
        out_wr   = 1'b1;
        out_addr = addr_full[ADDR_W-1:0];
        if (it_fin) state_d = DRAIN;
        else begin
          lat_new = 1'b1;
          // Same channel: the bias from the last read is still valid, reload it directly.
          if (it_i != ci) state_d = BIAS;
          else begin
            acc_ld  = 1'b1;
            state_d = RUN;
          end
        end
      end
      DRAIN: if (drain_cnt) begin
        state_d = DONE;
        if (wr_cnt != EXP_WR) err_set = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy = (state != IDLE);
    // Abort overrides everything; in DONE the layer is already ending, so just flag it.
    if (abort && state != IDLE) begin
      out_wr     = 1'b0;
      out_addr   = '0;
      it_en_ctrl = 1'b0;
      acc_en     = 1'b0;
      acc_ld     = 1'b0;
      bias_rd    = 1'b0;
      bias_addr  = 8'd0;
      lat_new    = 1'b0;
      err_set    = 1'b1;
      state_d    = (state == DONE) ? IDLE : DONE;
    end
    if (reset) begin
      busy       = 1'b0;
      done       = 1'b0;
      it_en_ctrl = 1'b0;
      bias_rd    = 1'b0;
      bias_addr  = 8'd0;
      acc_ld     = 1'b0;
      acc_en     = 1'b0;
      out_wr     = 1'b0;
      out_addr   = '0;
      it_rst     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ci        <= 8'd0;
      cj        <= 8'd0;
      ck        <= 8'd0;
      wr_cnt    <= 32'd0;
      bias_cnt  <= '0;
      drain_cnt <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (lat_zero)     {ci, cj, ck} <= 24'd0;
      else if (lat_new) {ci, cj, ck} <= {it_i, it_j, it_k};
      if (lat_zero)     wr_cnt <= 32'd0;
      else if (out_wr)  wr_cnt <= wr_cnt + 32'd1;
      bias_cnt  <= (state == BIAS) ? bias_cnt + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench: 2x2x2 layer driven by a small iterator/bias model, plus a
// second instance with a short bias timeout and a silent bias memory.
module tb_conv_layer_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, to_start = 1'b0;
  always #5 clk = ~clk;

  logic       busy, done, err, it_en_ctrl, it_rst, bias_rd, acc_ld, acc_en, out_wr;
  logic [7:0] bias_addr, out_addr;
  logic       bias_valid;
  logic [7:0] it_i = 8'd0, it_j = 8'd0, it_k = 8'd0;
  logic       it_fin = 1'b0;
  logic       it_en_sum;

  logic       to_busy, to_done, to_err, to_en_ctrl, to_it_rst, to_bias_rd, to_acc_ld, to_acc_en, to_wr;
  logic [7:0] to_bias_addr, to_out_addr;

  conv_layer_seq #(.CONV_DIM_OUT(2), .CONV_OUT_CH(2), .ADDR_W(8), .BIAS_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .it_en_ctrl(it_en_ctrl), .it_rst(it_rst), .it_en_sum(it_en_sum), .it_fin(it_fin),
    .it_i(it_i), .it_j(it_j), .it_k(it_k), .bias_rd(bias_rd), .bias_addr(bias_addr),
    .bias_valid(bias_valid), .acc_ld(acc_ld), .acc_en(acc_en), .out_wr(out_wr), .out_addr(out_addr));

  conv_layer_seq #(.CONV_DIM_OUT(2), .CONV_OUT_CH(2), .ADDR_W(8), .BIAS_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .start(to_start), .abort(1'b0), .busy(to_busy), .done(to_done),
    .err(to_err), .it_en_ctrl(to_en_ctrl), .it_rst(to_it_rst), .it_en_sum(1'b0), .it_fin(1'b0),
    .it_i(8'd0), .it_j(8'd0), .it_k(8'd0), .bias_rd(to_bias_rd), .bias_addr(to_bias_addr),
    .bias_valid(1'b0), .acc_ld(to_acc_ld), .acc_en(to_acc_en), .out_wr(to_wr), .out_addr(to_out_addr));

  // Iterator: 3 MAC cycles per pixel, order i,j,k; finishes after fin_limit pixels.
  int fin_limit = 8;
  int bias_delay = 1;
  int m = 0, pcnt = 0, brun = 0;
  assign it_en_sum  = !it_fin;
  assign bias_valid = bias_rd && (brun >= bias_delay - 1);

  always @(posedge clk) begin
    brun <= bias_rd ? brun + 1 : 0;
    if (it_rst) begin
      it_i <= 8'd0; it_j <= 8'd0; it_k <= 8'd0; m <= 0; pcnt <= 0; it_fin <= 1'b0;
    end else if (it_en_ctrl && !it_fin) begin
      if (m != 2) m <= m + 1;
      else begin
        m <= 0;
        pcnt <= pcnt + 1;
        if (pcnt + 1 == fin_limit) it_fin <= 1'b1;
        if (pcnt + 1 != 8) begin
          if (it_k != 8'd1) it_k <= it_k + 8'd1;
          else begin
            it_k <= 8'd0;
            if (it_j != 8'd1) it_j <= it_j + 8'd1;
            else begin it_j <= 8'd0; it_i <= it_i + 8'd1; end
          end
        end
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int wr_log[$];
  int run_log[$];
  int baddr_log[$];
  int run_len = 0, bias_visits = 0, ld_bias = 0, bad_ld = 0, done_cnt = 0;
  int to_bias_cyc = 0, to_wr_cnt = 0, to_done_cnt = 0;
  logic bias_rd_q = 1'b0, done_err = 1'b0, to_done_err = 1'b0;

  always @(negedge clk) begin
    if (out_wr) wr_log.push_back(int'(out_addr));
    if (bias_rd && !bias_rd_q) begin
      bias_visits <= bias_visits + 1;
      baddr_log.push_back(int'(bias_addr));
    end
    run_len <= bias_rd ? run_len + 1 : 0;
    if (!bias_rd && bias_rd_q) run_log.push_back(run_len);
    bias_rd_q <= bias_rd;
    if (acc_ld && bias_rd && bias_valid) ld_bias <= ld_bias + 1;
    if (acc_ld && bias_rd && !bias_valid) bad_ld <= bad_ld + 1;
    if (done) begin done_cnt <= done_cnt + 1; done_err <= err; end
    if (to_bias_rd) to_bias_cyc <= to_bias_cyc + 1;
    if (to_wr) to_wr_cnt <= to_wr_cnt + 1;
    if (to_done) begin to_done_cnt <= to_done_cnt + 1; to_done_err <= to_err; end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = done_cnt;
    for (int n = 0; n < budget && done_cnt == base; n++) tick();
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic chk_addrs(input string tag, input int base, input int cnt);
    chk({tag, "_n"}, wr_log.size() - base, cnt);
    for (int n = 0; n < cnt; n++) chk($sformatf("%s_a%0d", tag, n), wr_log[base + n], n);
  endtask

  initial begin
    int wb, rb, lb, vb, bb;
    logic found;
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_it_rst", it_rst, 1);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wr", out_wr, 0);
    chk("post_rst_it_rst", it_rst, 0);

    // Full layer, immediate bias; a stray start mid-layer must be ignored
    wb = wr_log.size(); vb = bias_visits; bb = baddr_log.size();
    pulse_start();
    chk("init_it_rst", it_rst, 1);
    chk("init_busy", busy, 1);
    repeat (10) tick();
    pulse_start();
    wait_done("l1_done", 300);
    chk("l1_err", done_err, 0);
    chk_addrs("l1", wb, 8);
    chk("l1_bias_visits", bias_visits - vb, 2);
    chk("l1_baddr0", baddr_log[bb], 0);
    chk("l1_baddr1", baddr_log[bb + 1], 1);
    tick(); tick();
    chk("l1_idle", busy, 0);
    chk("l1_one_done", done_cnt, 1);

    // Bias returned after 10 cycles on every visit
    bias_delay = 10;
    wb = wr_log.size(); rb = run_log.size(); lb = ld_bias;
    pulse_start();
    wait_done("l2_done", 400);
    chk("l2_err", done_err, 0);
    chk("l2_writes", wr_log.size() - wb, 8);
    chk("l2_run0", run_log[rb], 10);
    chk("l2_run1", run_log[rb + 1], 10);
    chk("l2_ld_on_valid", ld_bias - lb, 2);
    chk("l2_ld_early", bad_ld, 0);
    bias_delay = 1;

    // Bias timeout on the second instance
    to_start = 1'b1;
    tick();
    to_start = 1'b0;
    for (int n = 0; n < 40 && to_done_cnt == 0; n++) tick();
    chk("to_done", to_done_cnt, 1);
    chk("to_err", to_done_err, 1);
    chk("to_bias_cycles", to_bias_cyc, 4);
    chk("to_no_write", to_wr_cnt, 0);

    // Abort while running pixel 3, then restart from address 0
    wb = wr_log.size();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (wr_log.size() - wb == 3 && it_en_ctrl) found = 1'b1;
      else tick();
    end
    chk("ab_reach_px3", found, 1);
    abort = 1'b1;
    #1;
    chk("ab_wr_gated", out_wr, 0);
    chk("ab_en_gated", it_en_ctrl, 0);
    tick();
    abort = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_err", err, 1);
    repeat (3) tick();
    chk("ab_writes", wr_log.size() - wb, 3);
    chk("ab_idle", busy, 0);
    chk("ab_err_sticky", err, 1);
    wb = wr_log.size();
    pulse_start();
    chk("ab_err_clr", err, 0);
    wait_done("ab_re_done", 300);
    chk("ab_re_err", done_err, 0);
    chk_addrs("ab_re", wb, 8);

    // Reset asserted while in SAVE, with start held high
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (out_wr) found = 1'b1;
      else tick();
    end
    chk("rs_reach_save", found, 1);
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("rs_wr_now", out_wr, 0);
    tick();
    chk("rs_wr", out_wr, 0);
    chk("rs_busy", busy, 0);
    chk("rs_it_rst", it_rst, 1);
    tick();
    chk("rs_busy2", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rs_rel_busy", busy, 0);
    chk("rs_rel_wr", out_wr, 0);
    chk("rs_rel_err", err, 0);

    // Iterator finishes early after 5 pixels, fin coinciding with a coordinate change
    fin_limit = 5;
    wb = wr_log.size();
    pulse_start();
    wait_done("ef_done", 300);
    chk("ef_err", done_err, 1);
    chk_addrs("ef", wb, 5);
    fin_limit = 8;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
